countdown_timer_bank: RTL and testbench



---
 rtl/timer_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 37 +++
 rtl/countdown_timer_bank.sv | 98 +++++++++
 tb/tb_countdown_timer_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer bank.
//   timer_state_t  : per-channel FSM state encoding.
//   clks_per_tick(): number of clock cycles between prescaler ticks.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  function automatic int clks_per_tick(input int clk_hz, input int scale_factor);
    return clk_hz / scale_factor;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler that divides the board clock down to the timer tick.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high; restarts the count at 0
//   tick  : high for one cycle when the counter sits at its terminal value
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCALE_FACTOR = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CPT = clks_per_tick(CLK_HZ, SCALE_FACTOR);
  localparam int CW  = (CPT > 1) ? $clog2(CPT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Tick is decoded from the counter, so the first tick after reset is seen
  // by the channels on the CPT-th edge after reset is released.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of N_CH independent countdown timers sharing one tick prescaler.
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-high
//   start_value : shared load value, captured by any channel whose load is high
//   load        : per-channel load strobe (count and reload value, back to IDLE)
//   start       : per-channel start/resume strobe
//   pause       : per-channel pause strobe
//   auto_reload : per-channel level; reload at expiry instead of stopping
//   count       : flattened counts, channel i at [i*WIDTH +: WIDTH]
//   running     : channel is in RUN
//   done        : channel is in DONE
//   expired     : one-cycle pulse at each expiry
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SCALE_FACTOR = 1000,
  parameter int WIDTH        = 11,
  parameter int N_CH         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      start_value,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       pause,
  input  logic [N_CH-1:0]       auto_reload,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       running,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       expired
);

  logic tick;

  tick_prescaler #(
    .CLK_HZ      (CLK_HZ),
    .SCALE_FACTOR(SCALE_FACTOR)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_state_t     state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] reload_val;
    logic             exp_pulse;

    // An ignored start (RUN/DONE) does not mask a pause or tick in the same
    // cycle; only strobes that actually act take priority.
    always_ff @(posedge clk) begin
      if (reset) begin
        state      <= IDLE;
        cnt        <= '0;
        reload_val <= '0;
        exp_pulse  <= 1'b0;
      end else begin
        exp_pulse <= 1'b0;
        if (load[i]) begin
          cnt        <= start_value;
          reload_val <= start_value;
          state      <= IDLE;
        end else if (start[i] && (state == IDLE || state == PAUSED)) begin
          if (cnt != '0) begin
            state <= RUN;
          end else begin
            state     <= DONE;
            exp_pulse <= 1'b1;
          end
        end else if (pause[i] && state == RUN) begin
          state <= PAUSED;
        end else if (tick && state == RUN) begin
          if (cnt > WIDTH'(1)) begin
            cnt <= cnt - WIDTH'(1);
          end else begin
            // Expiry: count was 1 (0 in RUN cannot occur, treated the same).
            exp_pulse <= 1'b1;
            if (auto_reload[i] && reload_val != '0) begin
              cnt <= reload_val;
            end else begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt;
    assign running[i]              = (state == RUN);
    assign done[i]                 = (state == DONE);
    assign expired[i]              = exp_pulse;
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed bench for countdown_timer_bank with CLKS_PER_TICK = 4.
// Inputs change and outputs are sampled on the falling edge. After each reset
// release, "n" counts rising edges; channel ticks land on edges where n%4==0.
module tb_countdown_timer_bank;

  localparam int WIDTH = 11;
  localparam int N_CH  = 4;

  logic                  clk;
  logic                  reset;
  logic [WIDTH-1:0]      start_value;
  logic [N_CH-1:0]       load;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       pause;
  logic [N_CH-1:0]       auto_reload;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       running;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       expired;

  int ntests = 0;
  int nfail  = 0;
  int n      = 0;

  countdown_timer_bank #(
    .CLK_HZ      (40),
    .SCALE_FACTOR(10),
    .WIDTH       (WIDTH),
    .N_CH        (N_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_value(start_value),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .auto_reload(auto_reload),
    .count      (count),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] cnt(input int ch);
    return count[ch*WIDTH +: WIDTH];
  endfunction

  task automatic adv(input int k);
    repeat (k) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start_value = '0;
    load        = '0;
    start       = '0;
    pause       = '0;
    auto_reload = '0;
    repeat (3) @(negedge clk);

    chk("rst_count",   64'(count),   64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_expired", 64'(expired), 64'd0);

    // ---- 1: plain countdown from 10 on ch0
    reset = 1'b0; n = 0;
    start_value = 11'd10; load[0] = 1'b1;
    adv(1);                                   // N1
    chk("t1_load_count", 64'(cnt(0)), 64'd10);
    chk("t1_load_idle",  64'(running[0]), 64'd0);
    load[0] = 1'b0; start[0] = 1'b1;
    adv(1);                                   // N2
    chk("t1_running", 64'(running[0]), 64'd1);
    chk("t1_cnt_n2",  64'(cnt(0)), 64'd10);
    start[0] = 1'b0;
    adv(2);                                   // N4: first tick
    chk("t1_cnt_n4", 64'(cnt(0)), 64'd9);
    adv(35);                                  // N39
    chk("t1_cnt_n39", 64'(cnt(0)), 64'd1);
    chk("t1_noexp_n39", 64'(expired[0]), 64'd0);
    adv(1);                                   // N40
    chk("t1_cnt_zero", 64'(cnt(0)), 64'd0);
    chk("t1_expired",  64'(expired[0]), 64'd1);
    chk("t1_done",     64'(done[0]), 64'd1);
    chk("t1_stopped",  64'(running[0]), 64'd0);
    adv(1);                                   // N41
    chk("t1_exp_once", 64'(expired[0]), 64'd0);
    chk("t1_done_hold", 64'(done[0]), 64'd1);

    // ---- 2: pause at 6, hold, resume
    start_value = 11'd10; load[0] = 1'b1;
    adv(1);                                   // N42
    chk("t2_reload", 64'(cnt(0)), 64'd10);
    chk("t2_done_clr", 64'(done[0]), 64'd0);
    load[0] = 1'b0; start[0] = 1'b1;
    adv(1);                                   // N43
    start[0] = 1'b0;
    adv(13);                                  // N56: ticks at 44,48,52,56
    chk("t2_cnt6", 64'(cnt(0)), 64'd6);
    pause[0] = 1'b1;
    adv(1);                                   // N57
    pause[0] = 1'b0;
    chk("t2_paused", 64'(running[0]), 64'd0);
    adv(20);                                  // N77
    chk("t2_frozen", 64'(cnt(0)), 64'd6);
    chk("t2_still_paused", 64'(running[0]), 64'd0);
    start[0] = 1'b1;
    adv(1);                                   // N78
    start[0] = 1'b0;
    chk("t2_resumed", 64'(running[0]), 64'd1);
    adv(21);                                  // N99
    chk("t2_cnt1", 64'(cnt(0)), 64'd1);
    adv(1);                                   // N100
    chk("t2_cnt0", 64'(cnt(0)), 64'd0);
    chk("t2_exp",  64'(expired[0]), 64'd1);
    chk("t2_done", 64'(done[0]), 64'd1);

    // ---- 3: auto-reload on ch1
    auto_reload[1] = 1'b1; start_value = 11'd3; load[1] = 1'b1;
    adv(1);                                   // N101
    load[1] = 1'b0; start[1] = 1'b1;
    adv(1);                                   // N102
    start[1] = 1'b0;
    adv(6);                                   // N108
    chk("t3_cnt1", 64'(cnt(1)), 64'd1);
    adv(4);                                   // N112: reload
    chk("t3_reloaded", 64'(cnt(1)), 64'd3);
    chk("t3_exp", 64'(expired[1]), 64'd1);
    chk("t3_running", 64'(running[1]), 64'd1);
    chk("t3_not_done", 64'(done[1]), 64'd0);
    adv(1);                                   // N113
    chk("t3_exp_clr", 64'(expired[1]), 64'd0);
    adv(11);                                  // N124
    chk("t3_exp2", 64'(expired[1]), 64'd1);
    chk("t3_cnt3b", 64'(cnt(1)), 64'd3);
    adv(4);                                   // N128
    chk("t3_cnt2", 64'(cnt(1)), 64'd2);
    chk("t3_not_done2", 64'(done[1]), 64'd0);

    // ---- 4: load beats start; reload during RUN aborts quietly
    start_value = 11'd5; load[2] = 1'b1; start[2] = 1'b1;
    adv(1);                                   // N129
    chk("t4_cnt5", 64'(cnt(2)), 64'd5);
    chk("t4_idle", 64'(running[2]), 64'd0);
    load[2] = 1'b0;
    adv(1);                                   // N130
    start[2] = 1'b0;
    chk("t4_run", 64'(running[2]), 64'd1);
    adv(2);                                   // N132
    chk("t4_cnt4", 64'(cnt(2)), 64'd4);
    start_value = 11'd7; load[2] = 1'b1;
    adv(1);                                   // N133
    load[2] = 1'b0;
    chk("t4_cnt7", 64'(cnt(2)), 64'd7);
    chk("t4_abort_idle", 64'(running[2]), 64'd0);
    chk("t4_no_exp", 64'(expired[2]), 64'd0);
    adv(4);                                   // N137
    chk("t4_hold7", 64'(cnt(2)), 64'd7);
    chk("t4_no_exp2", 64'(expired[2]), 64'd0);

    // ---- 5: start with zero count
    start_value = 11'd0; load[3] = 1'b1;
    adv(1);                                   // N138
    load[3] = 1'b0; start[3] = 1'b1;
    chk("t5_not_done", 64'(done[3]), 64'd0);
    adv(1);                                   // N139
    start[3] = 1'b0;
    chk("t5_done", 64'(done[3]), 64'd1);
    chk("t5_exp", 64'(expired[3]), 64'd1);
    chk("t5_cnt0", 64'(cnt(3)), 64'd0);
    chk("t5_notrun", 64'(running[3]), 64'd0);
    adv(1);                                   // N140
    chk("t5_exp_clr", 64'(expired[3]), 64'd0);

    // ---- 6: concurrent run, then reset mid-count
    start_value = 11'd10; load[0] = 1'b1;
    adv(1);                                   // N141
    load[0] = 1'b0; start[0] = 1'b1;
    adv(1);                                   // N142
    start[0] = 1'b0;
    adv(2);                                   // N144
    chk("t6_cnt0", 64'(cnt(0)), 64'd9);
    chk("t6_cnt1", 64'(cnt(1)), 64'd1);
    chk("t6_both_run", 64'(running[1:0]), 64'd3);
    adv(1);                                   // N145
    reset = 1'b1;
    adv(1);                                   // N146
    chk("t6_rst_count",   64'(count),   64'd0);
    chk("t6_rst_running", 64'(running), 64'd0);
    chk("t6_rst_done",    64'(done),    64'd0);
    chk("t6_rst_expired", 64'(expired), 64'd0);
    reset = 1'b0; n = 0;
    start_value = 11'd5; load[0] = 1'b1;
    adv(1);                                   // N1 after release
    load[0] = 1'b0; start[0] = 1'b1;
    adv(1);                                   // N2
    start[0] = 1'b0;
    adv(1);                                   // N3
    chk("t6_pre_tick", 64'(cnt(0)), 64'd5);
    adv(1);                                   // N4
    chk("t6_first_tick", 64'(cnt(0)), 64'd4);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
